// File: rtl/square_pkg.sv
// square_pkg: definitions shared by the square-wave generator and meter.
//   SQUARE_WIDTH : default counter width for period/high measurement
//   sq_state_t   : measurement FSM states
package square_pkg;

    localparam int unsigned SQUARE_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH,
        LOW
    } sq_state_t;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-flop synchronizer for an asynchronous level, followed by
// one history flop used for edge detection.
//   clk, reset : system clock, synchronous active-high reset
//   in         : asynchronous input level
//   level      : synchronized level
//   rise       : one-cycle pulse, synchronized level went 0 -> 1
//   fall       : one-cycle pulse, synchronized level went 1 -> 0
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_level;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_level = r_sync[SYNC_STAGES-1];
    assign level   = w_level;
    assign rise    = w_level & ~r_hist;
    assign fall    = ~w_level & r_hist;

endmodule

// File: rtl/square_meas.sv
// square_meas: square-wave period / high-time meter.
//   clk, reset : system clock, synchronous active-high reset
//   enable     : measurement enable; low forces IDLE and holds outputs
//   in         : asynchronous square-wave input
//   period     : clk cycles between the last two rising edges
//   high       : clk cycles from rising to falling edge of that cycle
//   valid      : one-cycle strobe, period/high updated this cycle
//   overflow   : one-cycle strobe, counter hit max with no edge
module square_meas
    import square_pkg::*;
#(
    parameter int unsigned WIDTH       = SQUARE_WIDTH,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high,
    output logic             valid,
    output logic             overflow
);

    localparam logic [WIDTH-1:0]  CNT_MAX   = '1;
    localparam int unsigned       WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_warm_done;
    logic             w_cnt_max;
    logic [WIDTH-1:0] w_cnt_inc;

    sq_state_t        r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_htmp;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic             r_valid;
    logic             r_overflow;
    logic [WARM_W-1:0] r_warm;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .level(w_level),
        .rise (w_rise),
        .fall (w_fall)
    );

    // The synchronizer restarts from all-zero after reset, so its level is
    // meaningless until it has flushed. Holding IDLE for that long keeps an
    // input already high at reset from looking like a fresh rising edge.
    assign w_warm_done = (r_warm == WARM_DONE);
    assign w_cnt_max   = (r_cnt == CNT_MAX);
    // Saturating increment: a fall exactly at max must not wrap the count
    // seen by LOW; LOW then reports overflow unless the rise coincides.
    assign w_cnt_inc   = w_cnt_max ? r_cnt : r_cnt + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_htmp     <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            r_warm     <= '0;
        end else begin
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
            if (!w_warm_done) begin
                r_warm <= r_warm + WARM_W'(1);
            end

            if (!enable) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_warm_done && !w_level) begin
                            r_state <= ARMED;
                        end
                    end
                    ARMED: begin
                        if (w_rise) begin
                            r_state <= HIGH;
                            r_cnt   <= WIDTH'(1);
                        end
                    end
                    HIGH: begin
                        if (w_fall) begin
                            r_state <= LOW;
                            r_htmp  <= r_cnt;
                            r_cnt   <= w_cnt_inc;
                        end else if (w_cnt_max) begin
                            r_state    <= IDLE;
                            r_overflow <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    LOW: begin
                        if (w_rise) begin
                            r_state  <= HIGH;
                            r_period <= r_cnt;
                            r_high   <= r_htmp;
                            r_valid  <= 1'b1;
                            r_cnt    <= WIDTH'(1);
                        end else if (w_cnt_max) begin
                            r_state    <= IDLE;
                            r_overflow <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign period   = r_period;
    assign high     = r_high;
    assign valid    = r_valid;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_square_meas.sv
module tb_square_meas;

    typedef struct {
        bit ovf;
        int p;
        int h;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en16, in16, en4, in4;
    logic [15:0] period16, high16;
    logic [3:0]  period4, high4;
    logic        valid16, ovf16, valid4, ovf4;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q16[$];
    exp_t q4[$];

    // bench-side tracking of the open (not yet closed) measured cycle
    bit have16 = 0, have4 = 0;
    int p16 = 0, h16 = 0, p4 = 0, h4 = 0;
    logic prev_v16 = 1'b0, prev_v4 = 1'b0;

    always #5 clk = ~clk;

    square_meas #(.WIDTH(16), .SYNC_STAGES(2)) u16 (
        .clk(clk), .reset(reset), .enable(en16), .in(in16),
        .period(period16), .high(high16), .valid(valid16), .overflow(ovf16)
    );

    square_meas #(.WIDTH(4), .SYNC_STAGES(2)) u4 (
        .clk(clk), .reset(reset), .enable(en4), .in(in4),
        .period(period4), .high(high4), .valid(valid4), .overflow(ovf4)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // one high/low cycle on in16; its rise closes the previously open cycle
    task automatic wave16(input int h, input int l);
        if (have16) q16.push_back('{ovf: 1'b0, p: p16, h: h16});
        in16 = 1'b1;
        repeat (h) @(negedge clk);
        in16 = 1'b0;
        repeat (l) @(negedge clk);
        have16 = 1; p16 = h + l; h16 = h;
    endtask

    task automatic wave4(input int h, input int l);
        if (have4) q4.push_back('{ovf: 1'b0, p: p4, h: h4});
        in4 = 1'b1;
        repeat (h) @(negedge clk);
        in4 = 1'b0;
        repeat (l) @(negedge clk);
        have4 = 1; p4 = h + l; h4 = h;
    endtask

    task automatic drain16();
        for (int i = 0; i < 100 && q16.size() != 0; i++) @(negedge clk);
        check("u16_drain", q16.size(), 0);
    endtask

    task automatic drain4();
        for (int i = 0; i < 100 && q4.size() != 0; i++) @(negedge clk);
        check("u4_drain", q4.size(), 0);
    endtask

    always @(negedge clk) begin
        if (valid16 || ovf16) begin
            if (q16.size() == 0) begin
                check("u16_unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q16.pop_front();
                check("u16_kind_ovf", int'(ovf16), int'(e.ovf));
                if (!e.ovf) begin
                    check("u16_period", int'(period16), e.p);
                    check("u16_high", int'(high16), e.h);
                end
            end
        end
        if (valid16) check("u16_valid_width", int'(prev_v16), 0);
        prev_v16 <= valid16;
    end

    always @(negedge clk) begin
        if (valid4 || ovf4) begin
            if (q4.size() == 0) begin
                check("u4_unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("u4_kind_ovf", int'(ovf4), int'(e.ovf));
                if (!e.ovf) begin
                    check("u4_period", int'(period4), e.p);
                    check("u4_high", int'(high4), e.h);
                end
            end
        end
        if (valid4) check("u4_valid_width", int'(prev_v4), 0);
        prev_v4 <= valid4;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; en16 = 1'b1; in16 = 1'b1; en4 = 1'b0; in4 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_period16", int'(period16), 0);
        check("rst_high16", int'(high16), 0);
        check("rst_valid16", int'(valid16), 0);
        check("rst_ovf16", int'(ovf16), 0);
        check("rst_period4", int'(period4), 0);
        check("rst_valid4", int'(valid4), 0);
        reset = 1'b0;

        // input already high at reset: partial cycle discarded
        repeat (6) @(negedge clk);
        in16 = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) wave16(3, 3);

        // duty sweep
        wave16(1, 9);
        wave16(7, 2);
        wave16(3, 3);
        drain16();

        // enable dropped mid-LOW
        wave16(3, 2);
        repeat (4) @(negedge clk);
        drain16();
        en16 = 1'b0;
        have16 = 0;
        repeat (2) @(negedge clk);
        in16 = 1'b1;
        repeat (3) @(negedge clk);
        in16 = 1'b0;
        repeat (3) @(negedge clk);
        check("en_hold_period16", int'(period16), 6);
        check("en_hold_high16", int'(high16), 3);
        en16 = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) wave16(4, 4);

        // reset asserted mid-HIGH
        if (have16) q16.push_back('{ovf: 1'b0, p: p16, h: h16});
        in16 = 1'b1;
        repeat (8) @(negedge clk);
        check("pre_reset_drain16", q16.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        check("reset_period16", int'(period16), 0);
        check("reset_high16", int'(high16), 0);
        reset = 1'b0;
        have16 = 0;
        in16 = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 3; i++) wave16(2, 5);
        drain16();

        // WIDTH=4: overflow with input held high, then an edge exactly at max
        en4 = 1'b1;
        in4 = 1'b0;
        repeat (5) @(negedge clk);
        wave4(2, 3);
        wave4(2, 3);
        if (have4) q4.push_back('{ovf: 1'b0, p: p4, h: h4});
        q4.push_back('{ovf: 1'b1, p: 0, h: 0});
        have4 = 0;
        in4 = 1'b1;
        repeat (20) @(negedge clk);
        in4 = 1'b0;
        repeat (5) @(negedge clk);
        drain4();
        check("ovf_hold_period4", int'(period4), 5);
        check("ovf_hold_high4", int'(high4), 2);
        wave4(5, 10);
        wave4(2, 6);
        en4 = 1'b0;
        drain4();
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
